// File: rtl/seq_add_9bit_pkg.sv
// Shared calculator constants: datapath width, slice geometry and the
// sequential-adder state encoding.
package seq_add_9bit_pkg;

   localparam int unsigned WIDTH     = 9;
   localparam int unsigned SLICE     = 4;
   localparam int unsigned NSLICES   = (WIDTH + SLICE - 1) / SLICE;
   localparam int unsigned PAD_W     = NSLICES * SLICE;
   localparam int unsigned LAST_BITS = WIDTH - (NSLICES - 1) * SLICE;
   localparam int unsigned IDX_W     = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_add_9bit_if.sv
// Start/done handshake and operand/result bus of the sequential adder.
interface seq_add_9bit_if;
   import seq_add_9bit_pkg::*;

   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   modport master (
      output start, x, y, cin,
      input  in_ready, busy, done, sum, carry
   );

   modport slave (
      input  start, x, y, cin,
      output in_ready, busy, done, sum, carry
   );

endinterface

// File: rtl/seq_add_9bit_add_slice.sv
// Combinational W-bit ripple-carry adder slice.
module seq_add_9bit_add_slice #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum_c,
   output logic         cout_c
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < W; i++) begin
         sum_c[i]  = a[i] ^ b[i] ^ c[i];
         c[i+1]    = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout_c = c[W];
   end

endmodule

// File: rtl/seq_add_9bit.sv
// Multi-cycle adder: sum = x + y + cin, one SLICE-bit slice per clock through
// a single shared slice adder, sequenced by a start/done handshake.
module seq_add_9bit
   import seq_add_9bit_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   seq_add_9bit_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [PAD_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_int_q, carry_int_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;

   logic [PAD_W-1:0] x_ext, y_ext;
   logic [SLICE-1:0] a_sel, b_sel, s_sum;
   logic             s_cout;
   logic [SLICE:0]   s_ext;
   logic             slice_carry;

   // Operand slice selection for the current index; pad bits read as zero.
   always_comb begin
      x_ext = PAD_W'(x_q);
      y_ext = PAD_W'(y_q);
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NSLICES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sel = x_ext[i*SLICE +: SLICE];
            b_sel = y_ext[i*SLICE +: SLICE];
         end
      end
   end

   seq_add_9bit_add_slice #(.W(SLICE)) u_slice (
      .a      (a_sel),
      .b      (b_sel),
      .cin    (carry_int_q),
      .sum_c  (s_sum),
      .cout_c (s_cout)
   );

   // In a partial last slice the carry out of bit WIDTH-1 lands in sum bit LAST_BITS.
   always_comb begin
      s_ext       = {s_cout, s_sum};
      slice_carry = (idx_q == LAST_IDX) ? s_ext[LAST_BITS] : s_cout;
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      carry_int_d = carry_int_q;
      sum_d       = sum_q;
      carry_d     = carry_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               x_d         = bus.x;
               y_d         = bus.y;
               carry_int_d = bus.cin;
               idx_d       = '0;
               state_d     = ADD;
            end else begin
               state_d     = IDLE;
            end
         end
         ADD: begin
            for (int unsigned i = 0; i < NSLICES; i++) begin
               if (idx_q == IDX_W'(i)) acc_d[i*SLICE +: SLICE] = s_sum;
            end
            carry_int_d = slice_carry;
            idx_d       = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               sum_d   = acc_d[WIDTH-1:0];
               carry_d = slice_carry;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      done_d     = (state_d == DONE);
      busy_d     = (state_d == ADD);
      in_ready_d = (state_d == IDLE) || (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         carry_int_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         carry_int_q <= carry_int_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.sum      = sum_q;
   assign bus.carry    = carry_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_seq_add_9bit.sv
// Directed self-checking bench for seq_add_9bit.
module tb_seq_add_9bit;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [8:0] last_sum;

   always #5 clk = ~clk;

   seq_add_9bit_if bus_if ();

   seq_add_9bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start one operation and check exact 3-cycle latency and the result.
   task automatic run_op(input logic [8:0] xv, input logic [8:0] yv, input logic cv,
                         input logic [8:0] esum, input logic ecarry);
      bus_if.start = 1'b1;
      bus_if.x     = xv;
      bus_if.y     = yv;
      bus_if.cin   = cv;
      tick();
      bus_if.start = 1'b0;
      bus_if.x     = ~xv;
      bus_if.y     = ~yv;
      chk("busy_in_add", 32'(bus_if.busy), 32'd1);
      chk("in_ready_in_add", 32'(bus_if.in_ready), 32'd0);
      chk("sum_held_in_add", 32'(bus_if.sum), 32'(last_sum));
      tick();
      tick();
      chk("done_early", 32'(bus_if.done), 32'd0);
      tick();
      chk("done_pulse", 32'(bus_if.done), 32'd1);
      chk("sum", 32'(bus_if.sum), 32'(esum));
      chk("carry", 32'(bus_if.carry), 32'(ecarry));
      chk("in_ready_done", 32'(bus_if.in_ready), 32'd1);
      last_sum = esum;
      tick();
      chk("done_cleared", 32'(bus_if.done), 32'd0);
      chk("idle_in_ready", 32'(bus_if.in_ready), 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.x     = '0;
      bus_if.y     = '0;
      bus_if.cin   = 1'b0;
      last_sum     = '0;
      tick();
      tick();
      chk("rst_sum", 32'(bus_if.sum), 32'd0);
      chk("rst_carry", 32'(bus_if.carry), 32'd0);
      chk("rst_done", 32'(bus_if.done), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      rst = 1'b0;
      tick();

      run_op(9'd100, 9'd200, 1'b0, 9'd300, 1'b0);
      run_op(9'd255, 9'd1,   1'b0, 9'd256, 1'b0);
      run_op(9'd511, 9'd1,   1'b0, 9'd0,   1'b1);
      run_op(9'd300, 9'd411, 1'b1, 9'd200, 1'b1);

      // Back-to-back: second operands presented in the DONE cycle.
      bus_if.start = 1'b1;
      bus_if.x = 9'd5;  bus_if.y = 9'd7;  bus_if.cin = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("b2b_done1", 32'(bus_if.done), 32'd1);
      chk("b2b_sum1", 32'(bus_if.sum), 32'd12);
      bus_if.x = 9'd10; bus_if.y = 9'd20;
      tick();
      bus_if.start = 1'b0;
      chk("b2b_busy", 32'(bus_if.busy), 32'd1);
      chk("b2b_done_gap", 32'(bus_if.done), 32'd0);
      tick();
      tick();
      chk("b2b_hold", 32'(bus_if.sum), 32'd12);
      tick();
      chk("b2b_done2", 32'(bus_if.done), 32'd1);
      chk("b2b_sum2", 32'(bus_if.sum), 32'd30);
      tick();
      last_sum = 9'd30;

      // Start during ADD is ignored.
      bus_if.start = 1'b1;
      bus_if.x = 9'd3; bus_if.y = 9'd4;
      tick();
      bus_if.start = 1'b0;
      tick();
      bus_if.start = 1'b1;
      bus_if.x = 9'd50; bus_if.y = 9'd60;
      tick();
      bus_if.start = 1'b0;
      tick();
      chk("ign_done", 32'(bus_if.done), 32'd1);
      chk("ign_sum", 32'(bus_if.sum), 32'd7);
      tick();
      chk("ign_idle", 32'(bus_if.busy), 32'd0);
      tick();
      chk("ign_no_second_done", 32'(bus_if.done), 32'd0);
      chk("ign_sum_held", 32'(bus_if.sum), 32'd7);

      // Reset in the second ADD cycle.
      bus_if.start = 1'b1;
      bus_if.x = 9'd100; bus_if.y = 9'd100;
      tick();
      bus_if.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
      chk("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("mid_rst_sum", 32'(bus_if.sum), 32'd0);
      chk("mid_rst_carry", 32'(bus_if.carry), 32'd0);
      chk("mid_rst_done", 32'(bus_if.done), 32'd0);
      tick();
      tick();
      chk("mid_rst_no_done", 32'(bus_if.done), 32'd0);
      last_sum = 9'd0;
      run_op(9'd1, 9'd2, 1'b0, 9'd3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
